// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter in front of a single-ported, combinational-read data
// memory. The CPU port is parked: it is granted with zero latency whenever
// the arbiter is in the CPU state. A debug/loader port is served by moving to
// the DBG state for exactly one cycle. If the CPU keeps the memory busy, the
// debug port is forced in after STARVE_MAX consecutive contended CPU grants.
//
// Parameters
//   STARVE_MAX  consecutive contended CPU grants before one debug grant is
//               forced (legal range 1..15).
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   c_req/c_we/c_addr/c_wd   CPU request, write enable, byte address, data
//   c_gnt, c_stall, c_rd     CPU grant, stall (req & ~gnt), read data
//   d_req/d_we/d_addr/d_wd   debug request, write enable, address, data
//   d_gnt, d_rd              debug grant, read data
//   m_we, m_addr, m_wd       memory write enable, address, write data
//   m_rd                     memory combinational read data
//
// Optional feature (macro DMEM_ARB_STATS_EN)
//   cpu_acc_cnt, dbg_acc_cnt, stall_cnt: 32-bit wrapping counters of c_gnt,
//   d_gnt and c_stall cycles, cleared by reset.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    // CPU port
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wd,
    output logic        c_gnt,
    output logic        c_stall,
    output logic [31:0] c_rd,
    // debug / loader port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wd,
    output logic        d_gnt,
    output logic [31:0] d_rd,
    // data memory
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wd,
    input  logic [31:0] m_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0] cpu_acc_cnt,
    output logic [31:0] dbg_acc_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic {
        ST_CPU = 1'b0,
        ST_DBG = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;

    // Read data is broadcast; each requester only trusts it while granted.
    assign c_rd = m_rd;
    assign d_rd = m_rd;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_CPU;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        c_gnt      = 1'b0;
        d_gnt      = 1'b0;
        m_we       = 1'b0;
        m_addr     = c_addr;
        m_wd       = c_wd;

        unique case (state)
            ST_CPU: begin
                c_gnt = c_req;
                m_we  = c_req & c_we;
                if (!d_req) begin
                    starve_nxt = 4'd0;
                end else if (!c_req || starve_cnt == STARVE_LAST) begin
                    // Idle CPU, or the CPU has had its quota of contended
                    // grants: hand the next cycle to the debug port.
                    state_nxt  = ST_DBG;
                    starve_nxt = 4'd0;
                end else begin
                    // Below STARVE_LAST here, so the increment saturates by
                    // construction: reaching STARVE_LAST forces the DBG branch.
                    starve_nxt = starve_cnt + 4'd1;
                end
            end
            ST_DBG: begin
                d_gnt     = d_req;
                m_addr    = d_addr;
                m_wd      = d_wd;
                m_we      = d_req & d_we;
                state_nxt = ST_CPU;
                if (!d_req) begin
                    starve_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt  = ST_CPU;
                starve_nxt = 4'd0;
            end
        endcase

        // NOTE: grants and the write enable depend combinationally on the
        // request inputs, so clearing the state flops alone is not enough; the
        // outputs are also gated while reset is held, independent of the clock.
        if (!reset) begin
            c_gnt = 1'b0;
            d_gnt = 1'b0;
            m_we  = 1'b0;
        end
    end

    assign c_stall = reset & c_req & ~c_gnt;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_acc_cnt <= 32'd0;
            dbg_acc_cnt <= 32'd0;
            stall_cnt   <= 32'd0;
        end else begin
            if (c_gnt)   cpu_acc_cnt <= cpu_acc_cnt + 32'd1;
            if (d_gnt)   dbg_acc_cnt <= dbg_acc_cnt + 32'd1;
            if (c_stall) stall_cnt   <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed self-checking bench for dmem_arbiter (STARVE_MAX = 4). The bench
// owns a small word-addressed memory model driven by m_we/m_addr/m_wd and
// returning m_rd combinationally. Inputs change just after the falling edge;
// outputs are sampled 1 ns later, well away from the rising edge.
// Define DMEM_ARB_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wd;
    logic        c_gnt, c_stall;
    logic [31:0] c_rd;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wd;
    logic        d_gnt;
    logic [31:0] d_rd;
    logic        m_we;
    logic [31:0] m_addr, m_wd, m_rd;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] cpu_acc_cnt, dbg_acc_cnt, stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:63];

    dmem_arbiter #(.STARVE_MAX(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wd    (c_wd),
        .c_gnt   (c_gnt),
        .c_stall (c_stall),
        .c_rd    (c_rd),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wd    (d_wd),
        .d_gnt   (d_gnt),
        .d_rd    (d_rd),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wd    (m_wd),
        .m_rd    (m_rd)
`ifdef DMEM_ARB_STATS_EN
        ,
        .cpu_acc_cnt (cpu_acc_cnt),
        .dbg_acc_cnt (dbg_acc_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge.
    assign m_rd = mem[m_addr[7:2]];
    always @(posedge clk) begin
        if (m_we) mem[m_addr[7:2]] <= m_wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wd = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wd = 32'h0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[8]  = 32'h1234_5678;
        mem[12] = 32'hA5A5_A5A5;

        // Reset held with a CPU write pending: nothing may be granted.
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wd = 32'h1111_1111;
        #1;
        check("rst_c_gnt",   32'(c_gnt),   32'd0);
        check("rst_m_we",    32'(m_we),    32'd0);
        check("rst_c_stall", 32'(c_stall), 32'd0);
        check("rst_d_gnt",   32'(d_gnt),   32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_clk_c_gnt", 32'(c_gnt), 32'd0);
        check("rst_no_write",  mem[4],     32'h0);

        // Release: CPU read is granted in the same cycle.
        c_we = 1'b0;
        reset = 1'b1;
        #1;
        check("rel_c_gnt",   32'(c_gnt),   32'd1);
        check("rel_c_stall", 32'(c_stall), 32'd0);

        // CPU write 0xDEADBEEF to 0x10 (word 4), no debug traffic.
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wd = 32'hDEAD_BEEF;
        #1;
        check("cw_m_we",    32'(m_we),    32'd1);
        check("cw_m_addr",  m_addr,       32'h10);
        check("cw_m_wd",    m_wd,         32'hDEAD_BEEF);
        check("cw_c_stall", 32'(c_stall), 32'd0);
        @(negedge clk);
        c_we = 1'b0;
        #1;
        check("cw_mem4", mem[4], 32'hDEAD_BEEF);
        check("cr_c_rd", c_rd,   32'hDEAD_BEEF);

        // Debug read of 0x20 (word 8) with the CPU idle.
        @(negedge clk);
        idle_inputs();
        d_req = 1'b1; d_addr = 32'h20;
        #1;
        check("dr1_d_gnt", 32'(d_gnt), 32'd0);
        check("dr1_c_gnt", 32'(c_gnt), 32'd0);
        check("dr1_m_we",  32'(m_we),  32'd0);
        @(negedge clk);
        #1;
        check("dr2_d_gnt",  32'(d_gnt), 32'd1);
        check("dr2_m_addr", m_addr,     32'h20);
        check("dr2_d_rd",   d_rd,       32'h1234_5678);
        @(negedge clk);
        idle_inputs();
        c_req = 1'b1; c_addr = 32'h10;
        #1;
        check("dr3_cpu_c_gnt", 32'(c_gnt), 32'd1);
        check("dr3_d_gnt",     32'(d_gnt), 32'd0);

        // Fresh reset, then 10 cycles of continuous contention:
        // four CPU grants, one forced debug grant, repeating.
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        c_req = 1'b1; c_addr = 32'h40;
        d_req = 1'b1; d_addr = 32'h44;
        for (int k = 0; k < 10; k++) begin
            logic exp_dbg;
            exp_dbg = ((k % 5) == 4);
            #1;
            check($sformatf("cont%0d_c_gnt", k),   32'(c_gnt),   32'(!exp_dbg));
            check($sformatf("cont%0d_d_gnt", k),   32'(d_gnt),   32'(exp_dbg));
            check($sformatf("cont%0d_c_stall", k), 32'(c_stall), 32'(exp_dbg));
            check($sformatf("cont%0d_m_addr", k),  m_addr,       exp_dbg ? 32'h44 : 32'h40);
            @(negedge clk);
        end
        idle_inputs();
        #1;
`ifdef DMEM_ARB_STATS_EN
        check("stat_cpu",   cpu_acc_cnt, 32'd8);
        check("stat_dbg",   dbg_acc_cnt, 32'd2);
        check("stat_stall", stall_cnt,   32'd2);
`endif
        check("idle_c_gnt", 32'(c_gnt), 32'd0);

        // Debug write to 0x30 (word 12) aborted by reset during its DBG cycle.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wd = 32'hCAFE_F00D;
        #1;
        check("dw1_m_we", 32'(m_we), 32'd0);
        @(negedge clk);
        #1;
        check("dw2_d_gnt", 32'(d_gnt), 32'd1);
        check("dw2_m_we",  32'(m_we),  32'd1);
        reset = 1'b0;
        #1;
        check("dwr_m_we",  32'(m_we),  32'd0);
        check("dwr_d_gnt", 32'(d_gnt), 32'd0);
        @(negedge clk);
        #1;
        check("dwr_mem12",  mem[12],               32'hA5A5_A5A5);
        check("dwr_starve", 32'(dut.starve_cnt),   32'd0);
        idle_inputs();
        reset = 1'b1;
        c_req = 1'b1; c_addr = 32'h30;
        #1;
        check("dwr_rel_c_gnt", 32'(c_gnt), 32'd1);
        check("dwr_rel_c_rd",  c_rd,       32'hA5A5_A5A5);
        @(negedge clk);
        idle_inputs();
        #1;
        check("dwr_rel_starve", 32'(dut.starve_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
